// File: rtl/dffram_arbiter.sv
// Two-port round-robin arbiter in front of a single-port DFFRAM.
// Each access walks IDLE -> ISSUE -> RESP; one RAM access per three cycles.
module dffram_arbiter #(
    parameter int COLS = 1,
    localparam int A_WIDTH = 8 + $clog2(COLS)
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               p0_req,
    input  logic [3:0]         p0_we,
    input  logic [A_WIDTH-1:0] p0_addr,
    input  logic [31:0]        p0_wdata,
    output logic               p0_ack,
    output logic [31:0]        p0_rdata,
    input  logic               p1_req,
    input  logic [3:0]         p1_we,
    input  logic [A_WIDTH-1:0] p1_addr,
    input  logic [31:0]        p1_wdata,
    output logic               p1_ack,
    output logic [31:0]        p1_rdata,
    output logic               ram_en,
    output logic [3:0]         ram_we,
    output logic [A_WIDTH-1:0] ram_a,
    output logic [31:0]        ram_di,
    input  logic [31:0]        ram_do
);

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    state_t             state;
    logic               last_grant;
    logic               winner;
    logic               grant1;
    logic [3:0]         we_l;
    logic [A_WIDTH-1:0] addr_l;
    logic [31:0]        wdata_l;
    logic               en_r;
    logic               ack0_r;
    logic               ack1_r;

    // Returns 1 when port 1 should win; on a tie the port not granted last wins.
    function automatic logic pick_winner(input logic r0, input logic r1, input logic last);
        if (r0 && r1)
            return ~last;
        else
            return r1;
    endfunction

    assign grant1 = pick_winner(p0_req, p1_req, last_grant);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            winner     <= 1'b0;
            we_l       <= 4'b0000;
            addr_l     <= '0;
            wdata_l    <= 32'h0;
            en_r       <= 1'b0;
            ack0_r     <= 1'b0;
            ack1_r     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    ack0_r <= 1'b0;
                    ack1_r <= 1'b0;
                    if (p0_req || p1_req) begin
                        winner     <= grant1;
                        last_grant <= grant1;
                        we_l       <= grant1 ? p1_we    : p0_we;
                        addr_l     <= grant1 ? p1_addr  : p0_addr;
                        wdata_l    <= grant1 ? p1_wdata : p0_wdata;
                        en_r       <= 1'b1;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    // RAM captures the access at the end of this cycle; Do is valid in RESP.
                    en_r   <= 1'b0;
                    ack0_r <= ~winner;
                    ack1_r <= winner;
                    state  <= RESP;
                end
                RESP: begin
                    ack0_r <= 1'b0;
                    ack1_r <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    en_r   <= 1'b0;
                    ack0_r <= 1'b0;
                    ack1_r <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign ram_en   = en_r;
    assign ram_we   = en_r ? we_l : 4'b0000;
    assign ram_a    = addr_l;
    assign ram_di   = wdata_l;
    assign p0_ack   = ack0_r;
    assign p1_ack   = ack1_r;
    assign p0_rdata = ack0_r ? ram_do : 32'h0;
    assign p1_rdata = ack1_r ? ram_do : 32'h0;

endmodule

// File: tb/tb_dffram_arbiter.sv
// Scoreboard bench for dffram_arbiter (COLS=2) with a behavioural DFFRAM model.
module tb_dffram_arbiter;

    localparam int COLS = 2;
    localparam int AW   = 9;

    logic          CLK = 1'b0;
    logic          RST;
    logic          p0_req, p1_req;
    logic [3:0]    p0_we, p1_we;
    logic [AW-1:0] p0_addr, p1_addr;
    logic [31:0]   p0_wdata, p1_wdata;
    logic          p0_ack, p1_ack;
    logic [31:0]   p0_rdata, p1_rdata;
    logic          ram_en;
    logic [3:0]    ram_we;
    logic [AW-1:0] ram_a;
    logic [31:0]   ram_di;
    logic [31:0]   ram_do = 32'h0;

    dffram_arbiter #(.COLS(COLS)) dut (
        .CLK(CLK), .RST(RST),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_ack(p0_ack), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_ack(p1_ack), .p1_rdata(p1_rdata),
        .ram_en(ram_en), .ram_we(ram_we), .ram_a(ram_a), .ram_di(ram_di),
        .ram_do(ram_do)
    );

    always #5 CLK = ~CLK;

    // Behavioural DFFRAM: word i starts as 0xA5000000|i, Do registered on EN.
    logic [31:0] mem [0:256*COLS-1];
    logic        init_done = 1'b0;
    always @(posedge CLK) begin
        if (!init_done) begin
            for (int i = 0; i < 256*COLS; i++) mem[i] <= 32'hA500_0000 | 32'(i);
            init_done <= 1'b1;
        end else if (ram_en) begin
            ram_do <= mem[ram_a];
            for (int b = 0; b < 4; b++)
                if (ram_we[b]) mem[ram_a][8*b +: 8] <= ram_di[8*b +: 8];
        end
    end

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int n_vec  = 0;
    int n_miss = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    typedef struct packed { logic port; logic [31:0] rdata; } resp_t;
    typedef struct packed { logic [3:0] we; logic [AW-1:0] a; logic [31:0] di; } iss_t;
    resp_t resp_q[$];
    iss_t  iss_q[$];

    task automatic exp_resp(input logic port, input logic [31:0] d);
        resp_t e;
        e.port = port; e.rdata = d;
        resp_q.push_back(e);
    endtask

    task automatic exp_iss(input logic [3:0] we, input logic [AW-1:0] a, input logic [31:0] di);
        iss_t e;
        e.we = we; e.a = a; e.di = di;
        iss_q.push_back(e);
    endtask

    // Monitor: pops expectations whenever the DUT issues a RAM access or acks.
    logic prev0 = 1'b0, prev1 = 1'b0;
    int   ack_cyc0 = 0, ack_cyc1 = 0;
    always @(negedge CLK) begin
        if (ram_en) begin
            if (iss_q.size() == 0) begin
                chk("iss_unexpected", 64'(ram_a), 64'hFFFF);
            end else begin
                iss_t e;
                e = iss_q.pop_front();
                chk("iss_we", 64'(ram_we), 64'(e.we));
                chk("iss_a",  64'(ram_a),  64'(e.a));
                chk("iss_di", 64'(ram_di), 64'(e.di));
            end
        end else begin
            chk("idle_we", 64'(ram_we), 64'h0);
        end
        if (!p0_ack) chk("p0_rdata_idle", 64'(p0_rdata), 64'h0);
        if (!p1_ack) chk("p1_rdata_idle", 64'(p1_rdata), 64'h0);
        if (p0_ack || p1_ack) begin
            chk("ack_overlap", 64'(p0_ack & p1_ack), 64'h0);
            chk("ack_width", 64'((p0_ack & prev0) | (p1_ack & prev1)), 64'h0);
            if (p0_ack) ack_cyc0 <= cyc;
            if (p1_ack) ack_cyc1 <= cyc;
            if (resp_q.size() == 0) begin
                chk("ack_unexpected", {62'h0, p1_ack, p0_ack}, 64'h0);
            end else begin
                resp_t e;
                e = resp_q.pop_front();
                chk("ack_port", 64'(p1_ack), 64'(e.port));
                chk("ack_rdata", 64'(p1_ack ? p1_rdata : p0_rdata), 64'(e.rdata));
            end
        end
        prev0 <= p0_ack;
        prev1 <= p1_ack;
    end

    // Present one access on a port and hold it until its ack; returns just after
    // the edge ending the ack cycle with req still high. lat counts rising edges
    // from req assertion to the end of the ack cycle.
    task automatic req_access(input logic port, input logic [3:0] we, input logic [AW-1:0] a,
                              input logic [31:0] d, output int lat);
        int start;
        int n;
        logic got;
        start = cyc;
        n = 0;
        if (port) begin
            p1_req = 1'b1; p1_we = we; p1_addr = a; p1_wdata = d;
        end else begin
            p0_req = 1'b1; p0_we = we; p0_addr = a; p0_wdata = d;
        end
        got = 1'b0;
        while (!got && n < 30) begin
            @(negedge CLK);
            n++;
            got = port ? p1_ack : p0_ack;
        end
        if (!got) begin
            n_vec++;
            n_miss++;
            $display("FAIL ack_timeout: port %0d got no ack, want ack within 30 cycles", port);
        end
        lat = cyc + 1 - start;
        @(posedge CLK);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_ram_en"},   64'(ram_en),   64'h0);
        chk({tag, "_ram_we"},   64'(ram_we),   64'h0);
        chk({tag, "_ram_a"},    64'(ram_a),    64'h0);
        chk({tag, "_ram_di"},   64'(ram_di),   64'h0);
        chk({tag, "_acks"},     {62'h0, p1_ack, p0_ack}, 64'h0);
        chk({tag, "_p0_rdata"}, 64'(p0_rdata), 64'h0);
        chk({tag, "_p1_rdata"}, 64'(p1_rdata), 64'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, l0, l1;
        RST = 1'b1;
        p0_req = 1'b0; p0_we = 4'h0; p0_addr = '0; p0_wdata = 32'h0;
        p1_req = 1'b0; p1_we = 4'h0; p1_addr = '0; p1_wdata = 32'h0;
        repeat (3) @(posedge CLK);
        #1;
        @(negedge CLK);
        check_all_zero("reset");
        @(posedge CLK);
        #1;
        RST = 1'b0;

        // Simultaneous reads right after reset: p0 wins the first tie.
        exp_iss(4'h0, 9'h020, 32'h0);
        exp_iss(4'h0, 9'h021, 32'h0);
        exp_resp(1'b0, 32'hA500_0020);
        exp_resp(1'b1, 32'hA500_0021);
        fork
            begin req_access(1'b0, 4'h0, 9'h020, 32'h0, l0); p0_req = 1'b0; end
            begin req_access(1'b1, 4'h0, 9'h021, 32'h0, l1); p1_req = 1'b0; end
        join
        chk("tie_ack_gap", 64'(ack_cyc1 - ack_cyc0), 64'd3);

        // Write through p0, read back through p1.
        exp_iss(4'hF, 9'h005, 32'hDEAD_BEEF);
        exp_resp(1'b0, 32'hA500_0005);
        req_access(1'b0, 4'hF, 9'h005, 32'hDEAD_BEEF, lat);
        p0_req = 1'b0;
        exp_iss(4'h0, 9'h005, 32'h0);
        exp_resp(1'b1, 32'hDEAD_BEEF);
        req_access(1'b1, 4'h0, 9'h005, 32'h0, lat);
        p1_req = 1'b0;
        chk("read_latency", 64'(lat), 64'd3);

        // Both ports continuously pending for six grants: strict alternation.
        exp_iss(4'h0, 9'h030, 32'h0); exp_resp(1'b0, 32'hA500_0030);
        exp_iss(4'h0, 9'h040, 32'h0); exp_resp(1'b1, 32'hA500_0040);
        exp_iss(4'h0, 9'h031, 32'h0); exp_resp(1'b0, 32'hA500_0031);
        exp_iss(4'h0, 9'h041, 32'h0); exp_resp(1'b1, 32'hA500_0041);
        exp_iss(4'h0, 9'h032, 32'h0); exp_resp(1'b0, 32'hA500_0032);
        exp_iss(4'h0, 9'h042, 32'h0); exp_resp(1'b1, 32'hA500_0042);
        fork
            begin
                req_access(1'b0, 4'h0, 9'h030, 32'h0, l0);
                req_access(1'b0, 4'h0, 9'h031, 32'h0, l0);
                req_access(1'b0, 4'h0, 9'h032, 32'h0, l0);
                p0_req = 1'b0;
            end
            begin
                req_access(1'b1, 4'h0, 9'h040, 32'h0, l1);
                req_access(1'b1, 4'h0, 9'h041, 32'h0, l1);
                req_access(1'b1, 4'h0, 9'h042, 32'h0, l1);
                p1_req = 1'b0;
            end
        join

        // Byte-lane write: only lane 2 changes, ack returns the old word.
        exp_iss(4'hF, 9'h010, 32'h1122_3344); exp_resp(1'b0, 32'hA500_0010);
        req_access(1'b0, 4'hF, 9'h010, 32'h1122_3344, lat);
        p0_req = 1'b0;
        exp_iss(4'b0100, 9'h010, 32'hAAAA_0000); exp_resp(1'b1, 32'h1122_3344);
        req_access(1'b1, 4'b0100, 9'h010, 32'hAAAA_0000, lat);
        p1_req = 1'b0;
        exp_iss(4'h0, 9'h010, 32'h0); exp_resp(1'b0, 32'h11AA_3344);
        req_access(1'b0, 4'h0, 9'h010, 32'h0, lat);
        p0_req = 1'b0;

        // Reset during ISSUE of a p0 read: no ack, everything cleared.
        exp_iss(4'h0, 9'h060, 32'h0);
        p0_req = 1'b1; p0_we = 4'h0; p0_addr = 9'h060; p0_wdata = 32'h0;
        @(posedge CLK);
        #1;
        RST = 1'b1;
        p0_req = 1'b0;
        @(posedge CLK);
        #1;
        @(negedge CLK);
        check_all_zero("abort");
        @(posedge CLK);
        #1;
        RST = 1'b0;
        repeat (4) @(posedge CLK);
        #1;

        // Next tie must go to p0 again.
        exp_iss(4'h0, 9'h050, 32'h0);
        exp_iss(4'h0, 9'h051, 32'h0);
        exp_resp(1'b0, 32'hA500_0050);
        exp_resp(1'b1, 32'hA500_0051);
        fork
            begin req_access(1'b0, 4'h0, 9'h050, 32'h0, l0); p0_req = 1'b0; end
            begin req_access(1'b1, 4'h0, 9'h051, 32'h0, l1); p1_req = 1'b0; end
        join

        // Top word of the second column, and no aliasing onto the first.
        exp_iss(4'hF, 9'h1FF, 32'hCAFE_F00D); exp_resp(1'b1, 32'hA500_01FF);
        req_access(1'b1, 4'hF, 9'h1FF, 32'hCAFE_F00D, lat);
        p1_req = 1'b0;
        exp_iss(4'h0, 9'h1FF, 32'h0); exp_resp(1'b0, 32'hCAFE_F00D);
        req_access(1'b0, 4'h0, 9'h1FF, 32'h0, lat);
        p0_req = 1'b0;
        exp_iss(4'h0, 9'h0FF, 32'h0); exp_resp(1'b1, 32'hA500_00FF);
        req_access(1'b1, 4'h0, 9'h0FF, 32'h0, lat);
        p1_req = 1'b0;

        repeat (4) @(posedge CLK);
        #1;
        chk("resp_q_drained", 64'(resp_q.size()), 64'h0);
        chk("iss_q_drained",  64'(iss_q.size()),  64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
